// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO, configurable word length, parity and stop bits
// Frames are sent LSB first and chained with no idle gap while words are queued.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [DATA_BITS-1:0]                  wr_data,
    input  logic                                  wr_valid,
    output logic                                  wr_ready,
    input  logic                                  flush,
    output logic                                  txd,
    output logic                                  busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count,
    output logic                                  overflow
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP  = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   txd_q, txd_d;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;
    logic                   ovf_q;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    logic full, empty, push, pop, timer_last, start_frame;
    logic [DATA_BITS-1:0] head;

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = wr_valid && !full && !flush;
    assign head       = mem[rd_ptr_q];
    assign timer_last = (timer_q == TIMER_LAST);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_last ? '0 : timer_q + TW'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        txd_d       = txd_q;
        start_frame = 1'b0;
        pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                txd_d   = 1'b1;
                if (!empty) start_frame = 1'b1;
            end
            S_START: begin
                if (timer_last) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (timer_last) begin
                    if (idx_q == LAST_DATA) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (timer_last) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                    txd_d   = 1'b1;
                end
            end
            S_STOP: begin
                if (timer_last) begin
                    if (idx_q == LAST_STOP) begin
                        if (!empty) start_frame = 1'b1;
                        else        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Parity is precomputed from the whole word because the shifter is consumed bit by bit.
        if (start_frame) begin
            pop     = 1'b1;
            state_d = S_START;
            timer_d = '0;
            shift_d = head;
            par_d   = (PARITY == 1) ? ~^head : ^head;
            txd_d   = 1'b0;
        end
        if (flush) begin
            pop     = 1'b0;
            state_d = S_IDLE;
            timer_d = '0;
            idx_d   = '0;
            txd_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
                if (push && !pop)      count_q <= count_q + CW'(1);
                else if (!push && pop) count_q <= count_q - CW'(1);
                if (wr_valid && full) ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    assign txd        = txd_q;
    assign wr_ready   = !full;
    assign busy       = (state_q != S_IDLE) || !empty;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule
